// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: groups the byte-write handshake and status/serial outputs of uart_tx_fifo.
//   din    byte to enqueue              (master -> slave)
//   wr     single-cycle write strobe    (master -> slave)
//   full   FIFO holds all entries       (slave -> master)
//   empty  FIFO holds no entries        (slave -> master)
//   busy   serialiser is mid-frame      (slave -> master)
//   ovf    sticky dropped-write flag    (slave -> master)
//   tx     registered serial line       (slave -> master)
interface uart_tx_fifo_if;
   logic [7:0] din;
   logic       wr;
   logic       full;
   logic       empty;
   logic       busy;
   logic       ovf;
   logic       tx;

   modport master (
      output din, wr,
      input  full, empty, busy, ovf, tx
   );

   modport slave (
      input  din, wr,
      output full, empty, busy, ovf, tx
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter. Bytes written through a single-cycle strobe
// are queued in a 2^FIFO_AW entry FIFO and serialised LSB first onto tx.
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset; aborts any frame and flushes the FIFO
//   bus  uart_tx_fifo_if.slave: din/wr in; full/empty/busy/ovf/tx out
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_AW      = 3
) (
   input logic           clk,
   input logic           rst,
   uart_tx_fifo_if.slave bus
);

   localparam int unsigned Depth = 2 ** FIFO_AW;
   localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0]  BaudLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] CountFull = Depth[FIFO_AW:0];

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // ---------------------------------------------------------------- FIFO
   logic [7:0]         mem_q [Depth];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               ovf_q;
   logic               full, empty, push, pop;
   logic [7:0]         head;

   assign full  = (count_q == CountFull);
   assign empty = (count_q == '0);
   // Full is judged on the registered count, so a pop on the same edge never frees a slot.
   assign push  = bus.wr & ~full;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         if (bus.wr && full) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.din;
      end
   end

   // ---------------------------------------------------------- serialiser
   state_e          state_q, state_d;
   logic [CntW-1:0] baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            period_end;

   assign period_end = (baud_q == BaudLast);

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q + 1'b1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop       = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (period_end) begin
               baud_d    = '0;
               tx_d      = shift_q[0];
               bit_idx_d = 3'd0;
               state_d   = StData;
            end
         end
         StData: begin
            if (period_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  // Next bit is shift_q[1], i.e. bit 0 of the shifted value.
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (period_end) begin
               baud_d = '0;
               if (!empty) begin
                  // Chain straight into the next start bit, no idle gap.
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            baud_d  = '0;
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.full  = full;
   assign bus.empty = empty;
   assign bus.busy  = busy_q;
   assign bus.ovf   = ovf_q;
   assign bus.tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with CLKS_PER_BIT = 4. Stimulus pushes each
// byte expected on the line into a scoreboard queue; an independent monitor decodes every
// frame on tx and compares it against the queue head.
module tb_uart_tx_fifo;
   localparam int Cpb = 4;
   localparam int Aw  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_tx_fifo_if bus_if ();

   uart_tx_fifo #(
      .CLKS_PER_BIT(Cpb),
      .FIFO_AW     (Aw)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] sb [$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one byte for the next rising edge; return 1 time unit after that edge.
   task automatic wr_byte(input logic [7:0] b, input bit sent);
      bus_if.din = b;
      bus_if.wr  = 1'b1;
      @(posedge clk);
      #1;
      bus_if.wr = 1'b0;
      if (sent) sb.push_back(b);
   endtask

   task automatic wait_idle(input string name, input int exp_cyc);
      int n = 0;
      while (bus_if.busy && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, n, exp_cyc);
   endtask

   // ------------------------------------------------------------ monitor
   logic [9:0] mon_bits;
   logic       mon_glitch;
   logic       mon_abort;
   logic [7:0] mon_exp;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst && bus_if.tx == 1'b0) begin
            mon_bits   = '0;
            mon_glitch = 1'b0;
            mon_abort  = 1'b0;
            chk("frame_expected", (sb.size() > 0) ? 1 : 0, 1);
            mon_exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
            for (int s = 0; s < 10 * Cpb; s++) begin
               if (s > 0) @(negedge clk);
               if (!rst) begin
                  mon_abort = 1'b1;
                  break;
               end
               if (s % Cpb == 0) mon_bits[s / Cpb] = bus_if.tx;
               else if (bus_if.tx != mon_bits[s / Cpb]) mon_glitch = 1'b1;
            end
            if (!mon_abort) begin
               chk("frame_bits", int'(mon_bits), int'({1'b1, mon_exp, 1'b0}));
               chk("frame_bit_width", int'(mon_glitch), 0);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ----------------------------------------------------------- stimulus
   initial begin : stim
      int n;
      int lows;
      bus_if.wr  = 1'b0;
      bus_if.din = 8'h00;

      // Reset held with wr toggling: outputs stay at reset values.
      for (int i = 0; i < 5; i++) begin
         bus_if.wr  = (i % 2 == 0) ? 1'b1 : 1'b0;
         bus_if.din = 8'(8'hC0 + i);
         @(negedge clk);
         chk("rst_tx", int'(bus_if.tx), 1);
         chk("rst_busy", int'(bus_if.busy), 0);
         chk("rst_empty", int'(bus_if.empty), 1);
         chk("rst_full", int'(bus_if.full), 0);
         chk("rst_ovf", int'(bus_if.ovf), 0);
      end
      bus_if.wr = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_empty", int'(bus_if.empty), 1);

      // Single byte 0xA5.
      wr_byte(8'hA5, 1'b1);
      chk("single_tx_before_pop", int'(bus_if.tx), 1);
      chk("single_busy_before_pop", int'(bus_if.busy), 0);
      chk("single_empty_queued", int'(bus_if.empty), 0);
      @(posedge clk);
      #1;
      chk("single_tx_fall", int'(bus_if.tx), 0);
      chk("single_busy_rise", int'(bus_if.busy), 1);
      chk("single_empty_after_pop", int'(bus_if.empty), 1);
      wait_idle("single_busy_len", 10 * Cpb);
      repeat (3) @(posedge clk);
      #1;

      // Back-to-back: three frames, no gaps.
      wr_byte(8'h00, 1'b1);
      wr_byte(8'hFF, 1'b1);
      wr_byte(8'h3C, 1'b1);
      chk("b2b_empty_queued", int'(bus_if.empty), 0);
      n = 2;
      while (bus_if.busy && n < 300) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 8 * Cpb * 2 + 2 * Cpb * 2 - 0 && 0 == 1) n = n;
         if (n == 80) chk("b2b_empty_before_last_pop", int'(bus_if.empty), 0);
         if (n == 81) chk("b2b_empty_after_last_pop", int'(bus_if.empty), 1);
      end
      chk("b2b_busy_len", n - 1, 30 * Cpb);
      repeat (3) @(posedge clk);
      #1;

      // Ten writes into an eight-entry FIFO; the tenth is dropped.
      for (int i = 0; i < 10; i++) begin
         wr_byte(8'(i + 1), (i < 9));
         chk($sformatf("ovfl_full_%0d", i), int'(bus_if.full), (i >= 8) ? 1 : 0);
         chk($sformatf("ovfl_ovf_%0d", i), int'(bus_if.ovf), (i >= 9) ? 1 : 0);
      end
      wait_idle("ovfl_busy_len", 9 * 10 * Cpb - 8);
      rst = 1'b0;
      #1;
      chk("rst_clears_ovf", int'(bus_if.ovf), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Fill to full, then write 0x77 on the stop->start pop edge.
      for (int i = 0; i < 9; i++) wr_byte(8'(8'h11 + i), 1'b1);
      chk("simul_full", int'(bus_if.full), 1);
      chk("simul_ovf_clear", int'(bus_if.ovf), 0);
      repeat (32) @(posedge clk);
      #1;
      chk("simul_full_before_edge", int'(bus_if.full), 1);
      wr_byte(8'h77, 1'b0);
      chk("simul_count7_not_full", int'(bus_if.full), 0);
      chk("simul_ovf_set", int'(bus_if.ovf), 1);
      chk("simul_next_start", int'(bus_if.tx), 0);
      chk("simul_busy", int'(bus_if.busy), 1);
      wait_idle("simul_busy_len", 8 * 10 * Cpb);
      repeat (3) @(posedge clk);
      #1;

      // Reset during data bit 3 of 0xF0 with 0x55 still queued.
      wr_byte(8'hF0, 1'b1);
      wr_byte(8'h55, 1'b1);
      repeat (17) @(posedge clk);
      #2;
      chk("midrst_bit3_low", int'(bus_if.tx), 0);
      rst = 1'b0;
      #1;
      chk("midrst_tx_async", int'(bus_if.tx), 1);
      chk("midrst_busy", int'(bus_if.busy), 0);
      chk("midrst_empty", int'(bus_if.empty), 1);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (bus_if.tx == 1'b0) lows++;
      end
      chk("midrst_no_remnant", lows, 0);
      wr_byte(8'h3A, 1'b1);
      @(posedge clk);
      #1;
      chk("midrst_new_tx_fall", int'(bus_if.tx), 0);
      wait_idle("midrst_new_busy_len", 10 * Cpb);

      repeat (10) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
